// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide
// step per cycle, with valid/ready request and response handshakes.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic [4:0]      req_rd,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [4:0]      resp_rd,
  output logic            busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic              neg_q;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  // Multiply: {product high, multiplier/product low}. Divide: {remainder, quotient}.
  logic [2*XLEN-1:0] acc;

  logic              accept;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              special;
  logic [XLEN-1:0]   special_res;
  logic              is_div_q;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_sel;
  logic [XLEN-1:0]   fix_res;

  assign req_ready = (state == S_IDLE) && !flush;
  assign busy      = (state != S_IDLE);
  assign accept    = req_valid && req_ready;
  assign is_div_q  = op_q[2];

  always_comb begin
    a_signed = (req_op == OP_MUL) || (req_op == OP_MULH) || (req_op == OP_MULHSU) ||
               (req_op == OP_DIV) || (req_op == OP_REM);
    b_signed = (req_op == OP_MUL) || (req_op == OP_MULH) ||
               (req_op == OP_DIV) || (req_op == OP_REM);
    a_neg    = a_signed && req_a[XLEN-1];
    b_neg    = b_signed && req_b[XLEN-1];
    abs_a    = a_neg ? -req_a : req_a;
    abs_b    = b_neg ? -req_b : req_b;

    special     = 1'b0;
    special_res = '0;
    if (req_op[2] && (req_b == '0)) begin
      special     = 1'b1;
      special_res = req_op[1] ? req_a : '1;
    end else if (((req_op == OP_DIV) || (req_op == OP_REM)) &&
                 (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (req_b == '1)) begin
      special     = 1'b1;
      special_res = req_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, mag_b};
    acc_step  = '0;
    if (is_div_q) begin
      if (!div_diff[XLEN])
        acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
        acc_step = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc[XLEN-1:1]};
    end
  end

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    div_sel  = op_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    fix_res  = '0;
    if (is_div_q)
      fix_res = neg_q ? -div_sel : div_sel;
    else if (op_q == OP_MUL)
      fix_res = prod_fix[XLEN-1:0];
    else
      fix_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      neg_q      <= 1'b0;
      mag_a      <= '0;
      mag_b      <= '0;
      acc        <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_rd    <= '0;
    end else if (flush) begin
      state      <= S_IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q  <= req_op;
            rd_q  <= req_rd;
            neg_q <= (req_op[2] && req_op[1]) ? a_neg : (a_neg ^ b_neg);
            mag_a <= abs_a;
            mag_b <= abs_b;
            acc   <= req_op[2] ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
            if (special) begin
              state      <= S_DONE;
              resp_valid <= 1'b1;
              resp_data  <= special_res;
              resp_rd    <= req_rd;
            end else begin
              state <= S_CALC;
              cnt   <= CNT_W'(XLEN);
            end
          end
        end
        S_CALC: begin
          acc <= acc_step;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1))
            state <= S_FIXUP;
        end
        S_FIXUP: begin
          state      <= S_DONE;
          resp_valid <= 1'b1;
          resp_data  <= fix_res;
          resp_rd    <= rd_q;
        end
        S_DONE: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: arithmetic reference model, latency and
// handshake checks, flush and asynchronous reset behaviour.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic        exp_live = 1'b0;
  logic [31:0] exp_data = '0;
  logic [4:0]  exp_rd   = '0;

  muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_rd(resp_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: RV32M semantics via 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    case (op)
      3'd0: begin r = sa * sb; return r[31:0]; end
      3'd1: begin r = sa * sb; return r[63:32]; end
      3'd2: begin r = sa * ub; return r[63:32]; end
      3'd3: begin r = ua * ub; return r[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; r = sa / sb; return r[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; r = ua / ub; return r[31:0]; end
      3'd6: begin if (b == 0) return a; r = sa % sb; return r[31:0]; end
      default: begin if (b == 0) return a; r = ua % ub; return r[31:0]; end
    endcase
  endfunction

  // Continuous checker: any visible response must match the model's expectation.
  always @(posedge clk) begin
    #4;
    if (!rst) begin
      if (resp_valid) begin
        check(exp_live, "spurious_resp_valid", 32'(resp_valid), 32'(exp_live));
        check(resp_data == exp_data, "cmp_resp_data", resp_data, exp_data);
        check(resp_rd == exp_rd, "cmp_resp_rd", 32'(resp_rd), 32'(exp_rd));
      end
      check(req_ready == (!busy && !flush), "cmp_req_ready", 32'(req_ready),
            32'(!busy && !flush));
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op; req_a = a; req_b = b; req_rd = rd;
    exp_data = model(op, a, b);
    exp_rd   = rd;
    #1 check(req_ready == 1'b1, "issue_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    exp_live  = 1'b1;
    req_valid = 1'b0;
    req_op = 3'($urandom);
    req_a  = $urandom;
    req_b  = $urandom;
    req_rd = 5'($urandom);
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] lit,
                        input int lat, input int hold);
    int n;
    resp_ready = (hold == 0);
    check(model(op, a, b) == lit, {name, "_model_pin"}, model(op, a, b), lit);
    issue(op, a, b, rd);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 100);
    check(n == lat, {name, "_latency"}, 32'(n), 32'(lat));
    check(resp_data == lit, {name, "_data"}, resp_data, lit);
    check(resp_rd == rd, {name, "_rd"}, 32'(resp_rd), 32'(rd));
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      check(resp_valid == 1'b1, {name, "_hold_valid"}, 32'(resp_valid), 32'd1);
      check(resp_data == lit, {name, "_hold_data"}, resp_data, lit);
      check(req_ready == 1'b0, {name, "_hold_req_ready"}, 32'(req_ready), 32'd0);
      check(busy == 1'b1, {name, "_hold_busy"}, 32'(busy), 32'd1);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_live = 1'b0;
    check(resp_valid == 1'b0, {name, "_valid_drop"}, 32'(resp_valid), 32'd0);
    check(busy == 1'b0, {name, "_idle"}, 32'(busy), 32'd0);
    check(req_ready == 1'b1, {name, "_ready_again"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = '0;
    req_a = '0; req_b = '0; req_rd = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(resp_valid == 1'b0, "reset_resp_valid", 32'(resp_valid), 32'd0);
    check(resp_data == 32'd0, "reset_resp_data", resp_data, 32'd0);
    check(resp_rd == 5'd0, "reset_resp_rd", 32'(resp_rd), 32'd0);
    check(busy == 1'b0, "reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 34, 0);
    run_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 5'd4,  32'h4000_0000, 34, 0);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 34, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, 34, 0);
    run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFD, 34, 0);
    run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFF, 34, 0);
    run_op("divu",   3'd5, 32'hFFFF_FFFF,  32'h10,        5'd9,  32'h0FFF_FFFF, 34, 0);
    run_op("remu",   3'd7, 32'd100,        32'd7,         5'd10, 32'd2,         34, 0);
    run_op("div0",   3'd4, 32'd5,          32'd0,         5'd11, 32'hFFFF_FFFF, 1,  0);
    run_op("remu0",  3'd7, 32'h1234,       32'd0,         5'd12, 32'h1234,      1,  0);
    run_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1,  0);
    run_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'd0,         1,  0);
    run_op("bp_mul", 3'd0, 32'd1000,       32'd1000,      5'd15, 32'd1000000,   34, 10);
    run_op("b2b",    3'd5, 32'd1000,       32'd3,         5'd16, 32'd333,       34, 0);

    // Flush in the middle of CALC, with a competing request that must be refused.
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd20);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    req_valid = 1'b1; req_op = 3'd3; req_a = 32'd9; req_b = 32'd9; req_rd = 5'd21;
    #1 check(req_ready == 1'b0, "flush_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    exp_live = 1'b0;
    flush = 1'b0; req_valid = 1'b0;
    check(busy == 1'b0, "flush_idle", 32'(busy), 32'd0);
    check(resp_valid == 1'b0, "flush_resp_valid", 32'(resp_valid), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid || busy) seen = 1'b1;
    end
    check(!seen, "flush_no_resp", 32'(seen), 32'd0);
    run_op("post_flush_mulhu", 3'd3, 32'h8000_0001, 32'd6, 5'd22, 32'd3, 34, 0);

    // Asynchronous reset mid-CALC.
    issue(3'd5, 32'hDEAD_BEEF, 32'd17, 5'd25);
    repeat (5) @(negedge clk);
    exp_live = 1'b0;
    #2 rst = 1'b1;
    #1;
    check(resp_valid == 1'b0, "arst_resp_valid", 32'(resp_valid), 32'd0);
    check(resp_data == 32'd0, "arst_resp_data", resp_data, 32'd0);
    check(resp_rd == 5'd0, "arst_resp_rd", 32'(resp_rd), 32'd0);
    check(busy == 1'b0, "arst_busy", 32'(busy), 32'd0);
    check(req_ready == 1'b1, "arst_req_ready", 32'(req_ready), 32'd1);
    #1 rst = 1'b0;
    run_op("post_rst_rem", 3'd6, 32'd100, 32'hFFFF_FFF9, 5'd26, 32'd2, 34, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
